// File: rtl/axi_ram_ctrl.sv
// axi_ram_ctrl: backend sequencer between the AXI slave channel FIFOs and a
// single-port synchronous RAM. Write and read bursts share the RAM port and
// are arbitrated round-robin at burst granularity.
module axi_ram_ctrl #(
  parameter  int C_AW      = 32,
  parameter  int C_ID      = 16,
  parameter  int C_DW      = 128,
  parameter  int C_OB      = 4,
  parameter  int C_RAM_AW  = 12,
  localparam int AX_INFO_W = C_ID + C_AW + 8 + 3 + 2
) (
  input  logic                      aclk_s,
  input  logic                      rst_n,
  input  logic                      awch_empty,
  input  logic [AX_INFO_W-1:0]      awch_info_i,
  output logic                      awch_pop,
  input  logic                      wch_empty,
  input  logic [C_DW+C_DW/8:0]      wch_info_i,
  output logic                      wch_pop,
  input  logic                      bch_full,
  output logic                      bch_push,
  output logic [C_ID+1:0]           bch_info_o,
  input  logic                      arch_empty,
  input  logic [AX_INFO_W-1:0]      arch_info_i,
  output logic                      arch_pop,
  input  logic                      rch_full,
  output logic                      rch_push,
  output logic [C_ID+C_DW+2:0]      rch_info_o,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic [C_RAM_AW-1:0]       ram_addr,
  output logic [C_DW-1:0]           ram_wdata,
  output logic [C_DW/8-1:0]         ram_wstrb,
  input  logic [C_DW-1:0]           ram_rdata
);

  localparam int ADDR_LSB = 13;
  localparam int ID_LSB   = 13 + C_AW;

  typedef enum logic [1:0] {IDLE, WR, WRESP, RD} state_t;

  state_t            state_q, state_d;
  logic              rr_last_rd;          // 1: most recent contended grant went to read
  logic [C_ID-1:0]   id_q;
  logic [C_AW-1:0]   addr_q, addr_nxt;
  logic [7:0]        len_q, cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              decerr_q, slverr_q;
  logic              rd_vld_q, rd_last_q;

  logic [AX_INFO_W-1:0] ax_in;
  logic [C_AW-1:0]   in_addr;
  logic              both_pend, grant_wr, grant_rd, advance, last_beat;
  logic              wlast;
  logic [C_AW-1:0]   step, bound, incr_a, wrap_a;
  logic              wrap_ok;

  assign both_pend = !awch_empty && !arch_empty;
  assign grant_wr  = (state_q == IDLE) && !awch_empty && (arch_empty || rr_last_rd);
  assign grant_rd  = (state_q == IDLE) && !arch_empty && (awch_empty || !rr_last_rd);
  assign ax_in     = grant_wr ? awch_info_i : arch_info_i;
  assign in_addr   = ax_in[ADDR_LSB +: C_AW];
  assign last_beat = (cnt_q == len_q);
  assign wlast     = wch_info_i[C_DW + C_DW/8];

  // Next beat address for FIXED / INCR / WRAP; illegal wrap lengths and
  // the reserved burst code fall back to INCR.
  always_comb begin
    step     = C_AW'(1) << size_q;
    bound    = (C_AW'(len_q) + C_AW'(1)) << size_q;
    incr_a   = addr_q + step;
    wrap_a   = (addr_q & ~(bound - C_AW'(1))) | (incr_a & (bound - C_AW'(1)));
    wrap_ok  = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    addr_nxt = incr_a;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = wrap_ok ? wrap_a : incr_a;
      default: addr_nxt = incr_a;
    endcase
  end

  // Next-state logic and FIFO/RAM strobes.
  always_comb begin
    state_d   = state_q;
    awch_pop  = 1'b0;
    arch_pop  = 1'b0;
    wch_pop   = 1'b0;
    bch_push  = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = '0;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          awch_pop = 1'b1;
          state_d  = WR;
        end else if (grant_rd) begin
          arch_pop = 1'b1;
          state_d  = RD;
        end
      end
      WR: begin
        if (!wch_empty) begin
          wch_pop = 1'b1;
          advance = 1'b1;
          if (!decerr_q) begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = addr_q[C_OB +: C_RAM_AW];
            ram_wdata = wch_info_i[C_DW/8 +: C_DW];
            ram_wstrb = wch_info_i[C_DW/8-1:0];
          end
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        if (!bch_full) begin
          bch_push = 1'b1;
          state_d  = IDLE;
        end
      end
      RD: begin
        if (!rch_full) begin
          advance = 1'b1;
          if (!decerr_q) begin
            ram_cs   = 1'b1;
            ram_addr = addr_q[C_OB +: C_RAM_AW];
          end
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst context, beat counter, arbitration pointer and read pipeline stage.
  always_ff @(posedge aclk_s or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_last_rd <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      decerr_q   <= 1'b0;
      slverr_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= (state_q == RD) && !rch_full;
      rd_last_q <= (state_q == RD) && !rch_full && last_beat;
      if (grant_wr || grant_rd) begin
        id_q     <= ax_in[ID_LSB +: C_ID];
        addr_q   <= in_addr;
        len_q    <= ax_in[12:5];
        size_q   <= ax_in[4:2];
        burst_q  <= ax_in[1:0];
        cnt_q    <= '0;
        decerr_q <= (in_addr >> (C_OB + C_RAM_AW)) != '0;
        slverr_q <= 1'b0;
        if (both_pend) rr_last_rd <= grant_rd;
      end
      if (advance) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + 8'd1;
        if ((state_q == WR) && (wlast != last_beat)) slverr_q <= 1'b1;
      end
    end
  end

  // Response formatting; the read-side context registers stay valid during
  // the final push because new burst info is only latched at the end of the
  // grant cycle it may overlap.
  always_comb begin
    bch_info_o = {id_q, decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00)};
    rch_push   = rd_vld_q;
    rch_info_o = {id_q,
                  (rd_vld_q && !decerr_q) ? ram_rdata : {C_DW{1'b0}},
                  (rd_vld_q && decerr_q) ? 2'b11 : 2'b00,
                  rd_last_q};
  end

endmodule

// File: tb/tb_axi_ram_ctrl.sv
// Scoreboard bench for axi_ram_ctrl: transaction-level model of the RAM
// contents and burst address sequences; a monitor pops and compares.
module tb_axi_ram_ctrl;
  localparam int AW  = 32;
  localparam int IDW = 16;
  localparam int DW  = 128;
  localparam int AXW = IDW + AW + 13;
  localparam int WW  = DW + DW/8 + 1;

  typedef struct { logic we; logic [11:0] addr; logic [127:0] data; logic [15:0] strb; } ram_exp_t;
  typedef struct { logic [15:0] id; logic [127:0] data; logic [1:0] resp; logic last; } r_exp_t;

  logic aclk_s, rst_n;
  logic awch_empty, awch_pop, wch_empty, wch_pop, bch_full, bch_push;
  logic arch_empty, arch_pop, rch_full, rch_push, ram_cs, ram_we;
  logic [AXW-1:0] awch_info_i, arch_info_i;
  logic [WW-1:0]  wch_info_i;
  logic [IDW+1:0] bch_info_o;
  logic [IDW+DW+2:0] rch_info_o;
  logic [11:0] ram_addr;
  logic [127:0] ram_wdata, ram_rdata;
  logic [15:0] ram_wstrb;

  axi_ram_ctrl #(.C_AW(AW), .C_ID(IDW), .C_DW(DW), .C_OB(4), .C_RAM_AW(12)) dut (
    .aclk_s(aclk_s), .rst_n(rst_n),
    .awch_empty(awch_empty), .awch_info_i(awch_info_i), .awch_pop(awch_pop),
    .wch_empty(wch_empty), .wch_info_i(wch_info_i), .wch_pop(wch_pop),
    .bch_full(bch_full), .bch_push(bch_push), .bch_info_o(bch_info_o),
    .arch_empty(arch_empty), .arch_info_i(arch_info_i), .arch_pop(arch_pop),
    .rch_full(rch_full), .rch_push(rch_push), .rch_info_o(rch_info_o),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata));

  logic [AXW-1:0] aw_q[$], ar_q[$];
  logic [WW-1:0]  w_q[$];
  ram_exp_t       exp_ram[$];
  logic [17:0]    exp_b[$];
  r_exp_t         exp_r[$];
  logic [127:0]   ram_mem [4096];
  logic [127:0]   gold    [4096];

  int total = 0, bad = 0, cyc = 0, ar_cyc = 0;
  bit lat_arm = 0, lat_en = 0, noise = 0;
  logic p_aw, p_w, p_ar, p_cs, p_we;
  logic [11:0] p_addr;
  logic [127:0] p_wd;
  logic [15:0] p_st;

  initial begin
    aclk_s = 1'b0;
    forever #5 aclk_s = ~aclk_s;
  end

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] step, nb, base;
    step = 32'd1 << size;
    nb   = (32'(len) + 32'd1) << size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      base = a - (a % nb);
      return base + ((a - base + step) % nb);
    end
    return a + step;
  endfunction

  task automatic refresh();
    awch_empty  = (aw_q.size() == 0);
    awch_info_i = awch_empty ? '0 : aw_q[0];
    arch_empty  = (ar_q.size() == 0);
    arch_info_i = arch_empty ? '0 : ar_q[0];
    wch_empty   = (w_q.size() == 0);
    wch_info_i  = wch_empty ? '0 : w_q[0];
  endtask

  // early >= 0 puts wlast on that beat instead of the last; dfix >= 0 gives data dfix+i, full strobes
  task automatic issue_write(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int early, input int dfix);
    logic [31:0] a;
    logic [127:0] d, g;
    logic [15:0] s;
    logic wl, slv, dec;
    a = addr; slv = 0;
    dec = (addr >> 16) != 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (dfix >= 0) begin d = 128'(dfix + i); s = 16'hFFFF; end
      else begin d = {$urandom, $urandom, $urandom, $urandom}; s = 16'($urandom); end
      wl = (early >= 0) ? (i == early) : (i == int'(len));
      if (wl != (i == int'(len))) slv = 1;
      w_q.push_back({wl, d, s});
      if (!dec) begin
        exp_ram.push_back('{we: 1'b1, addr: a[15:4], data: d, strb: s});
        g = gold[a[15:4]];
        for (int b = 0; b < 16; b++) if (s[b]) g[8*b +: 8] = d[8*b +: 8];
        gold[a[15:4]] = g;
      end
      a = next_addr(a, size, len, burst);
    end
    aw_q.push_back({id, addr, len, size, burst});
    exp_b.push_back({id, dec ? 2'b11 : (slv ? 2'b10 : 2'b00)});
    refresh();
  endtask

  task automatic issue_read(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic dec;
    a = addr;
    dec = (addr >> 16) != 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (!dec) exp_ram.push_back('{we: 1'b0, addr: a[15:4], data: '0, strb: '0});
      exp_r.push_back('{id: id, data: dec ? 128'd0 : gold[a[15:4]], resp: dec ? 2'b11 : 2'b00,
                        last: (i == int'(len))});
      a = next_addr(a, size, len, burst);
    end
    ar_q.push_back({id, addr, len, size, burst});
    refresh();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_ram.size() + exp_b.size() + exp_r.size() + aw_q.size() + w_q.size() + ar_q.size()) != 0
           && n < budget) begin
      @(negedge aclk_s);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout got=%0d cycles pending=%0d want=0", n,
               exp_ram.size() + exp_b.size() + exp_r.size());
    end
    repeat (2) @(negedge aclk_s);
  endtask

  // FIFO/RAM environment plus monitor: inputs change at posedge+1, outputs sampled at posedge+8.
  task automatic env();
    r_exp_t er;
    ram_exp_t e;
    logic [127:0] m;
    logic [17:0] eb;
    forever begin
      @(posedge aclk_s);
      #1;
      if (p_aw && aw_q.size() > 0) void'(aw_q.pop_front());
      if (p_w  && w_q.size()  > 0) void'(w_q.pop_front());
      if (p_ar && ar_q.size() > 0) void'(ar_q.pop_front());
      if (p_cs && p_we) begin
        m = ram_mem[p_addr];
        for (int b = 0; b < 16; b++) if (p_st[b]) m[8*b +: 8] = p_wd[8*b +: 8];
        ram_mem[p_addr] = m;
      end
      if (p_cs && !p_we) ram_rdata = ram_mem[p_addr];
      else ram_rdata = {$urandom, $urandom, $urandom, $urandom};
      refresh();
      #7;
      cyc++;
      if (!rst_n) begin
        total++;
        if ({awch_pop, wch_pop, arch_pop, bch_push, bch_info_o, rch_push, rch_info_o,
             ram_cs, ram_we, ram_addr, ram_wdata, ram_wstrb} != '0) begin
          bad++;
          $display("FAIL reset_outputs got=nonzero want=0");
        end
      end else begin
        if (ram_cs) begin
          total++;
          if (exp_ram.size() == 0) begin
            bad++;
            $display("FAIL ram_unexpected got=we%0b addr=%h want=no_access", ram_we, ram_addr);
          end else begin
            e = exp_ram.pop_front();
            if (ram_we !== e.we || ram_addr !== e.addr ||
                (e.we && (ram_wdata !== e.data || ram_wstrb !== e.strb))) begin
              bad++;
              $display("FAIL ram_access got=we%0b a=%h d=%h s=%h want=we%0b a=%h d=%h s=%h",
                       ram_we, ram_addr, ram_wdata, ram_wstrb, e.we, e.addr, e.data, e.strb);
            end
          end
        end
        if (rch_full) begin
          total++;
          if (ram_cs && !ram_we) begin
            bad++;
            $display("FAIL read_stall got=ram_cs=1 want=0");
          end
        end
        if (bch_push) begin
          total++;
          eb = (exp_b.size() != 0) ? exp_b.pop_front() : 18'h3FFFF;
          if (bch_info_o !== eb || bch_full) begin
            bad++;
            $display("FAIL bresp got=%h full=%0b want=%h", bch_info_o, bch_full, eb);
          end
        end
        if (rch_push) begin
          if (lat_arm) begin
            lat_arm = 0;
            if (lat_en) begin
              total++;
              if (cyc - ar_cyc != 2) begin
                bad++;
                $display("FAIL read_latency got=%0d want=2", cyc - ar_cyc);
              end
            end
          end
          total++;
          if (exp_r.size() == 0) begin
            bad++;
            $display("FAIL r_unexpected got=%h want=none", rch_info_o);
          end else begin
            er = exp_r.pop_front();
            if (rch_info_o !== {er.id, er.data, er.resp, er.last}) begin
              bad++;
              $display("FAIL rbeat got=%h want=%h", rch_info_o, {er.id, er.data, er.resp, er.last});
            end
          end
        end
        if (arch_pop) begin
          ar_cyc = cyc;
          lat_arm = 1;
        end
      end
      p_aw = awch_pop; p_w = wch_pop; p_ar = arch_pop;
      p_cs = ram_cs; p_we = ram_we; p_addr = ram_addr; p_wd = ram_wdata; p_st = ram_wstrb;
    end
  endtask

  task automatic noise_gen();
    forever begin
      @(negedge aclk_s);
      if (noise) begin
        bch_full = ($urandom % 4) == 0;
        rch_full = ($urandom % 4) == 0;
      end
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int early;
    rst_n = 0; bch_full = 0; rch_full = 0; ram_rdata = '0;
    p_aw = 0; p_w = 0; p_ar = 0; p_cs = 0; p_we = 0; p_addr = '0; p_wd = '0; p_st = '0;
    for (int i = 0; i < 4096; i++) begin ram_mem[i] = '0; gold[i] = '0; end
    refresh();
    fork
      env();
      noise_gen();
    join_none
    repeat (4) @(negedge aclk_s);
    rst_n = 1;
    @(negedge aclk_s);

    // contention out of reset: write wins; second contention: read wins
    issue_write(16'h0001, 32'h0400, 8'd1, 3'd4, 2'b01, -1, 'h10);
    issue_read (16'h0002, 32'h0800, 8'd1, 3'd4, 2'b01);
    wait_idle(200);
    issue_read (16'h0003, 32'h0400, 8'd1, 3'd4, 2'b01);
    issue_write(16'h0004, 32'h0C00, 8'd0, 3'd4, 2'b01, -1, 'h20);
    wait_idle(200);

    issue_write(16'd5, 32'h0100, 8'd0, 3'd4, 2'b01, -1, 'h55);
    wait_idle(200);
    issue_write(16'd7, 32'h0200, 8'd3, 3'd4, 2'b01, -1, 'hA0);
    wait_idle(200);
    lat_en = 1;
    issue_read(16'd7, 32'h0200, 8'd3, 3'd4, 2'b01);
    wait_idle(200);
    lat_en = 0;
    issue_write(16'd9, 32'h0130, 8'd3, 3'd4, 2'b10, -1, 'hC0);
    wait_idle(200);
    issue_read(16'd9, 32'h0130, 8'd3, 3'd4, 2'b10);
    wait_idle(200);

    // long read with a 10-cycle back-pressure window mid-burst
    issue_read(16'd3, 32'h0100, 8'd15, 3'd4, 2'b01);
    repeat (5) @(negedge aclk_s);
    rch_full = 1;
    repeat (10) @(negedge aclk_s);
    rch_full = 0;
    wait_idle(300);

    issue_write(16'h0011, 32'h0001_0000, 8'd1, 3'd4, 2'b01, -1, -1);
    wait_idle(200);
    issue_read(16'h0012, 32'h0001_0000, 8'd2, 3'd4, 2'b01);
    wait_idle(200);
    issue_write(16'h0022, 32'h0300, 8'd3, 3'd4, 2'b01, 2, -1);
    wait_idle(200);

    noise = 1;
    for (int t = 0; t < 60; t++) begin
      size  = 3'($urandom_range(0, 4));
      burst = 2'($urandom);
      case ($urandom % 3)
        0: len = 8'(1 << $urandom_range(1, 4)) - 8'd1;
        1: len = 8'd0;
        default: len = 8'($urandom_range(0, 15));
      endcase
      addr = 32'($urandom_range(0, 16'hFFFF)) & ~((32'd1 << size) - 32'd1);
      if ($urandom % 8 == 0) addr = addr | (32'h0001_0000 << $urandom_range(0, 15));
      if ($urandom % 2 == 0) begin
        early = (len != 0 && $urandom % 6 == 0) ? int'($urandom_range(0, int'(len) - 1)) : -1;
        issue_write(16'($urandom), addr, len, size, burst, early, -1);
      end else begin
        issue_read(16'($urandom), addr, len, size, burst);
      end
      wait_idle(500);
    end
    noise = 0;
    bch_full = 0;
    rch_full = 0;
    repeat (3) @(negedge aclk_s);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
